// File: rtl/sl_router_pkg.sv
// sl_router_pkg: shared command-word constants, error codes and arbiter states.
package sl_router_pkg;
  localparam int CMD_WIDTH = 34;
  localparam int HMB = 33;
  localparam int LMB = 32;
  localparam logic [1:0] CONFIG = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STATUS = 2'd2;
  localparam logic [1:0] INST_ADDR = 2'd3;
  typedef enum logic [1:0] {ERR_NONE, ERR_ADDR, ERR_INST, ERR_STALL} err_e;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PASS, S_DRAIN} state_e;
endpackage

// File: rtl/sl_rr_pick.sv
// sl_rr_pick: combinational round-robin pick of the first valid requester after ptr.
module sl_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic                 any
);
  always_comb begin
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) if (valid[i]) onehot = N'(1) << i;
    // a candidate above ptr beats any wrapped one
    for (int i = N - 1; i >= 0; i--) if (valid[i] && i > int'(ptr)) onehot = N'(1) << i;
  end
  assign any = |valid;
endmodule

// File: rtl/sl_cmd_arbiter.sv
// sl_cmd_arbiter: transaction-level round-robin merge of requester command streams into
// the router command FIFO, inserting INST_ADDR words and dropping malformed traffic.
module sl_cmd_arbiter
  import sl_router_pkg::*;
#(
  parameter int REQ_COUNT = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int CHANNEL_COUNT = 2,
  parameter int STALL_LIMIT = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQ_COUNT-1:0]             req_valid,
  input  logic [CMD_WIDTH*REQ_COUNT-1:0]   req_data,
  input  logic [ADDR_WIDTH*REQ_COUNT-1:0]  req_addr,
  input  logic [REQ_COUNT-1:0]             req_last,
  output logic [REQ_COUNT-1:0]             req_ready,
  input  logic                             fifo_write_full,
  output logic [CMD_WIDTH-1:0]             fifo_write_data,
  output logic                             fifo_write_inc,
  output logic [REQ_COUNT-1:0]             grant,
  output logic [ADDR_WIDTH-1:0]            cur_addr,
  output logic                             addr_valid,
  output logic                             err_pulse,
  output logic [1:0]                       err_code
);
  localparam int PW = $clog2(REQ_COUNT);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  state_e state, nxt;
  err_e err_now, err_q;
  logic [PW-1:0] g, rr_ptr, pick_idx;
  logic [REQ_COUNT-1:0] pick_oh;
  logic any, legal, acc, rdy, timeout, sel_valid, sel_last;
  logic [ADDR_WIDTH-1:0] addr_g, pick_addr;
  logic [CMD_WIDTH-1:0] sel_data;
  logic [SW-1:0] stall_cnt;
  sl_rr_pick #(.N(REQ_COUNT)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr),
    .onehot(pick_oh),
    .any(any)
  );
  always_comb begin
    pick_idx = '0;
    pick_addr = '0;
    sel_data = '0;
    sel_valid = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (pick_oh[i]) begin
        pick_idx = PW'(i);
        pick_addr = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
      end
      if (grant[i]) begin
        sel_data = req_data[CMD_WIDTH*i +: CMD_WIDTH];
        sel_valid = req_valid[i];
        sel_last = req_last[i];
      end
    end
  end
  assign legal = int'(pick_addr[ADDR_WIDTH-1:1]) < CHANNEL_COUNT;
  assign timeout = state == S_PASS && !sel_valid && int'(stall_cnt) == STALL_LIMIT - 1;
  always_comb begin
    nxt = state;
    rdy = 1'b0;
    acc = 1'b0;
    err_now = ERR_NONE;
    fifo_write_inc = 1'b0;
    fifo_write_data = '0;
    case (state)
      S_IDLE: if (any) begin
        nxt = !legal ? S_DRAIN : (addr_valid && pick_addr == cur_addr) ? S_PASS : S_ADDR;
        err_now = legal ? ERR_NONE : ERR_ADDR;
      end
      S_ADDR: begin
        fifo_write_inc = !fifo_write_full;
        fifo_write_data = {INST_ADDR, 32'(addr_g)};
        nxt = fifo_write_full ? S_ADDR : S_PASS;
      end
      S_PASS: begin
        rdy = !fifo_write_full;
        acc = sel_valid && rdy;
        fifo_write_data = sel_data;
        fifo_write_inc = acc && sel_data[HMB:LMB] != INST_ADDR;
        err_now = (acc && sel_data[HMB:LMB] == INST_ADDR) ? ERR_INST : timeout ? ERR_STALL : ERR_NONE;
        nxt = ((acc && sel_last) || timeout) ? S_IDLE : S_PASS;
      end
      default: begin
        rdy = 1'b1;
        acc = sel_valid;
        nxt = (acc && sel_last) ? S_IDLE : S_DRAIN;
      end
    endcase
    if (rst) begin
      rdy = 1'b0;
      fifo_write_inc = 1'b0;
      fifo_write_data = '0;
    end
  end
  assign req_ready = rdy ? grant : '0;
  assign err_code = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= '0;
      g <= '0;
      addr_g <= '0;
      cur_addr <= '0;
      addr_valid <= 1'b0;
      rr_ptr <= PW'(REQ_COUNT - 1);
      stall_cnt <= '0;
      err_pulse <= 1'b0;
      err_q <= ERR_NONE;
    end else begin
      state <= nxt;
      stall_cnt <= (state == S_PASS && nxt == S_PASS && !sel_valid) ? stall_cnt + 1'b1 : '0;
      err_pulse <= err_now != ERR_NONE;
      if (err_now != ERR_NONE) err_q <= err_now;
      if (state == S_IDLE && any) begin
        g <= pick_idx;
        grant <= pick_oh;
        addr_g <= pick_addr;
      end
      if (state != S_IDLE && nxt == S_IDLE) begin
        grant <= '0;
        rr_ptr <= g;
      end
      if (state == S_ADDR && !fifo_write_full) begin
        cur_addr <= addr_g;
        addr_valid <= 1'b1;
      end
      // a timed-out transaction leaves the router's instance selection unknown
      if (timeout) addr_valid <= 1'b0;
    end
  end
endmodule
